// File: rtl/instruction_fetcher.sv
// Instruction prefetcher: issues single-word requests to a BRAM-style medium,
// buffers returned words with their addresses in a small FIFO, and handles
// CPU redirects by flushing the FIFO and discarding any in-flight word.
module instruction_fetcher #(
    parameter int unsigned ADDRS      = 256,
    parameter int unsigned OP_SIZE    = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned ADDR_SIZE = $clog2(ADDRS)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    output logic [ADDR_SIZE-1:0] mem_addr_out,
    output logic                 mem_ready_out,
    input  logic [OP_SIZE-1:0]   mem_instruction_in,
    input  logic                 mem_valid_in,
    input  logic                 jump_in,
    input  logic [ADDR_SIZE-1:0] jump_addr_in,
    output logic [OP_SIZE-1:0]   instr_out,
    output logic [ADDR_SIZE-1:0] instr_addr_out,
    output logic                 instr_valid_out,
    input  logic                 instr_ready_in
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(ADDRS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [ADDR_SIZE-1:0] pc_q, pc_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic                 discard_q, discard_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [OP_SIZE-1:0]   fifo_instr_q [FIFO_DEPTH];
    logic [ADDR_SIZE-1:0] fifo_addr_q  [FIFO_DEPTH];

    logic [ADDR_SIZE-1:0] pc_inc;
    logic [CNT_W:0]       count_plus_one;
    logic                 push;
    logic                 pop;

    // Wrapping PC increment, safe for non-power-of-two address spaces.
    assign pc_inc = (pc_q == LAST_ADDR) ? '0 : pc_q + ADDR_SIZE'(1);
    assign count_plus_one = {1'b0, count_q} + (CNT_W + 1)'(1);

    // A redirect kills both the returning word and any pop in the same cycle.
    assign push = (state_q == WAIT) && mem_valid_in && !discard_q && !jump_in;
    assign pop  = instr_valid_out && instr_ready_in && !jump_in;

    // Fetch FSM, PC and discard-flag next state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        discard_d = discard_q;
        case (state_q)
            IDLE: begin
                if (!jump_in && (count_plus_one <= DEPTH_EXT)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // Latch the request address so the medium sees it stable in WAIT.
                addr_d  = pc_q;
                state_d = WAIT;
                if (jump_in) begin
                    discard_d = 1'b1;
                end
            end
            WAIT: begin
                if (mem_valid_in) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                    if (!discard_q && !jump_in) begin
                        pc_d = pc_inc;
                    end
                end else if (jump_in) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (jump_in) begin
            pc_d = jump_addr_in;
        end
    end

    // FIFO pointer and occupancy next state; a jump empties the buffer.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (jump_in) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            addr_q    <= '0;
            discard_q <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage; contents are only observed while count_q is non-zero.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= mem_instruction_in;
            fifo_addr_q[wr_ptr_q]  <= pc_q;
        end
    end

    // Outputs: request strobe only in REQ, head data forced to 0 when empty.
    always_comb begin
        mem_ready_out   = (state_q == REQ);
        mem_addr_out    = (state_q == REQ) ? pc_q : addr_q;
        instr_valid_out = (count_q != '0);
        instr_out       = instr_valid_out ? fifo_instr_q[rd_ptr_q] : '0;
        instr_addr_out  = instr_valid_out ? fifo_addr_q[rd_ptr_q] : '0;
    end

endmodule

// File: doc/instruction_fetcher.md
INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

Interface
REQ-001 SHALL have parameter ADDRS, default 256: instruction address space in words; ADDR_SIZE = $clog2(ADDRS).
REQ-002 SHALL have parameter OP_SIZE, default 8: instruction width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: prefetch buffer entries, power of two, at least 2.
REQ-004 SHALL have port clk_in, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port mem_addr_out, output, ADDR_SIZE bits: fetch address to the instruction medium addr_in.
REQ-007 SHALL have port mem_ready_out, output, 1 bit: request strobe to the medium ready_in.
REQ-008 SHALL have port mem_instruction_in, input, OP_SIZE bits: returned word from the medium instruction_out.
REQ-009 SHALL have port mem_valid_in, input, 1 bit: one-cycle return pulse from the medium valid_out.
REQ-010 SHALL have port jump_in, input, 1 bit: redirect request from the CPU.
REQ-011 SHALL have port jump_addr_in, input, ADDR_SIZE bits: redirect target, sampled when jump_in=1.
REQ-012 SHALL have port instr_out, output, OP_SIZE bits: FIFO head instruction.
REQ-013 SHALL have port instr_addr_out, output, ADDR_SIZE bits: address of the FIFO head instruction.
REQ-014 SHALL have port instr_valid_out, output, 1 bit: FIFO non-empty.
REQ-015 SHALL have port instr_ready_in, input, 1 bit: consumer pop; a transfer occurs when instr_valid_out=1 and instr_ready_in=1.

Function
REQ-016 SHALL implement FSM states IDLE, REQ and WAIT.
REQ-017 In IDLE, SHALL enter REQ when (FIFO count + 1) <= FIFO_DEPTH and no jump_in that cycle; otherwise it SHALL stay in IDLE.
REQ-018 In REQ, SHALL drive mem_ready_out=1 for exactly one cycle with mem_addr_out=fetch PC, then enter WAIT.
REQ-019 mem_ready_out SHALL be 0 in every state other than REQ.
REQ-020 In WAIT, mem_addr_out SHALL be held constant until mem_valid_in is seen, because the medium addresses the BRAM combinationally.
REQ-021 On mem_valid_in in WAIT with the discard flag clear, SHALL push {mem_instruction_in, fetch PC} into the FIFO, increment the PC, and enter IDLE.
REQ-022 On mem_valid_in in WAIT with the discard flag set, SHALL drop the word, clear the discard flag, leave the PC unchanged and enter IDLE.
REQ-023 PC increment SHALL wrap from ADDRS-1 to 0, including when ADDRS is not a power of two.
REQ-024 On jump_in=1, SHALL set PC <= jump_addr_in.
REQ-025 On jump_in=1, SHALL empty the FIFO in the same cycle; instr_valid_out SHALL be 0 on the next cycle.
REQ-026 On jump_in=1 in REQ or WAIT, SHALL set the discard flag; the FSM SHALL still complete WAIT, and no new request SHALL be issued until the outstanding mem_valid_in returns.
REQ-027 jump_in together with a pop SHALL discard the pop: the FIFO is flushed and the pop has no separate effect.
REQ-028 jump_in together with mem_valid_in SHALL drop the returning word.
REQ-029 Push and pop in the same cycle SHALL both occur and leave the count unchanged.
REQ-030 A push SHALL never occur when the FIFO is full; this is guaranteed by the issue rule in REQ-017.
REQ-031 Latency: mem_valid_in in cycle N with an empty FIFO SHALL give instr_valid_out=1 in cycle N+1.
REQ-032 Outputs instr_out and instr_addr_out SHALL be X-safe: both read 0 when the FIFO is empty.
REQ-033 mem_valid_in outside WAIT SHALL be ignored.

Reset
REQ-034 While rst_in=0, SHALL force: FSM=IDLE, PC=0, FIFO empty, discard flag=0, mem_ready_out=0, mem_addr_out=0, instr_valid_out=0, instr_out=0, instr_addr_out=0.
REQ-035 Reset mid-WAIT SHALL abandon the outstanding request; the bench SHALL reset the medium concurrently.
REQ-036 After rst_in rises, the first mem_ready_out pulse SHALL occur on the second rising edge, with mem_addr_out=0.

Verification
REQ-037 Streaming with medium model and instr_ready_in=1: fetched addresses SHALL be 0,1,2,3…; each instr_addr_out SHALL equal its word's BRAM index; there SHALL be no duplicates or gaps.
REQ-038 Backpressure with instr_ready_in=0 and FIFO_DEPTH=4: exactly 4 requests SHALL be issued, mem_ready_out SHALL then stay 0, and instr_addr_out SHALL stay 0; releasing instr_ready_in SHALL resume from address 4.
REQ-039 Jump to 0x80 while in WAIT for address 5: the word for 5 SHALL be dropped, the next request SHALL be 0x80 only after mem_valid_in, and the first output SHALL be instr_addr_out=0x80.
REQ-040 Wrap with ADDRS=200 and jump to 198: output addresses SHALL be 198, 199, 0, 1.
REQ-041 Simultaneous events: jump_in together with a pop and mem_valid_in in one cycle SHALL leave the FIFO empty next cycle, drop the word, and set PC=jump target.
REQ-042 Asserting rst_in=0 asynchronously between edges while in WAIT SHALL make all outputs 0 immediately; after release, fetch SHALL restart at address 0.
